// File: rtl/fifo_param.sv
// ============================================================================
// fifo_param -- single-clock FIFO with occupancy count, threshold flags and sticky errors
// Rev 1.0
// ============================================================================
`default_nettype none

module fifo_param #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       write,
  input  logic                       read,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       clr_err,
  output logic [WIDTH-1:0]           data_out,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int                  c_AW    = $clog2(DEPTH);
  localparam logic [c_AW:0]       c_DEPTH = DEPTH[c_AW:0];
  localparam logic [c_AW:0]       c_AF    = AF_LEVEL[c_AW:0];
  localparam logic [c_AW:0]       c_AE    = AE_LEVEL[c_AW:0];

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW-1:0]  r_wr_ptr;
  logic [c_AW-1:0]  r_rd_ptr;
  logic [c_AW:0]    r_count;
  logic [WIDTH-1:0] r_data_out;
  logic             r_overflow;
  logic             r_underflow;

  logic             w_rd_acc;
  logic             w_wr_acc;
  logic             w_ovf_set;
  logic             w_unf_set;

  assign full         = (r_count == c_DEPTH);
  assign empty        = (r_count == '0);
  assign almost_full  = (r_count >= c_AF);
  assign almost_empty = (r_count <= c_AE);

  // A read on a full FIFO frees a slot on the same edge, so the write may proceed.
  assign w_rd_acc  = read && !empty;
  assign w_wr_acc  = write && (!full || w_rd_acc);
  assign w_ovf_set = write && !w_wr_acc;
  assign w_unf_set = read && !w_rd_acc;

  always_ff @(posedge clk) begin
    if (w_wr_acc && !reset) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_data_out  <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd_acc) begin
        r_data_out <= r_mem[r_rd_ptr];
        r_rd_ptr   <= r_rd_ptr + 1'b1;
      end
      if (w_wr_acc && !w_rd_acc) begin
        r_count <= r_count + 1'b1;
      end else if (w_rd_acc && !w_wr_acc) begin
        r_count <= r_count - 1'b1;
      end
      // A new error in the same cycle as clr_err wins.
      r_overflow  <= (r_overflow  && !clr_err) || w_ovf_set;
      r_underflow <= (r_underflow && !clr_err) || w_unf_set;
    end
  end

  assign data_out  = r_data_out;
  assign count     = r_count;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

endmodule

`default_nettype wire

// File: tb/tb_fifo_param.sv
// ============================================================================
// tb_fifo_param -- directed self-checking bench for fifo_param (WIDTH=8, DEPTH=8)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_fifo_param;

  logic       clk;
  logic       reset;
  logic       write;
  logic       read;
  logic [7:0] data_in;
  logic       clr_err;
  logic [7:0] data_out;
  logic [3:0] count;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic       overflow;
  logic       underflow;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] q[$];
  logic [7:0] exp_d;

  fifo_param #(.WIDTH(8), .DEPTH(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .write        (write),
    .read         (read),
    .data_in      (data_in),
    .clr_err      (clr_err),
    .data_out     (data_out),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs applied after a falling edge, held over one rising edge, sampled at the next falling edge.
  task automatic cyc(input logic w, input logic r, input logic [7:0] d, input logic c);
    write = w; read = r; data_in = d; clr_err = c;
    @(negedge clk);
    write = 1'b0; read = 1'b0; clr_err = 1'b0;
  endtask

  initial begin
    reset = 1'b1; write = 1'b0; read = 1'b0; data_in = 8'h00; clr_err = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_ae", almost_empty, 1);
    check("rst_af", almost_full, 0);
    check("rst_dout", data_out, 0);
    check("rst_ovf", overflow, 0);
    check("rst_unf", underflow, 0);

    // Fill with 0x01..0x08, watching thresholds on the way.
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1, 1'b0, 8'(i), 1'b0);
      check("fill_count", count, i);
      check("fill_af", almost_full, (i >= 6) ? 1 : 0);
      check("fill_ae", almost_empty, (i <= 2) ? 1 : 0);
    end
    check("fill_full", full, 1);
    check("fill_empty", empty, 0);

    // Overflow: write at full with no read is dropped.
    cyc(1'b1, 1'b0, 8'hAA, 1'b0);
    check("ovf_count", count, 8);
    check("ovf_flag", overflow, 1);

    for (int i = 1; i <= 8; i++) begin
      cyc(1'b0, 1'b1, 8'h00, 1'b0);
      check("drain_data", data_out, i);
      check("drain_count", count, 8 - i);
    end
    check("drain_empty", empty, 1);
    check("ovf_sticky", overflow, 1);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    check("ovf_clr", overflow, 0);

    // Underflow: data_out holds its last value.
    cyc(1'b0, 1'b1, 8'h00, 1'b0);
    check("unf_dout", data_out, 8'h08);
    check("unf_flag", underflow, 1);
    check("unf_count", count, 0);
    // Error and clr_err together keep the flag set.
    cyc(1'b0, 1'b1, 8'h00, 1'b1);
    check("unf_clr_collide", underflow, 1);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    check("unf_clr", underflow, 0);

    // Simultaneous at full.
    for (int i = 1; i <= 8; i++) cyc(1'b1, 1'b0, 8'(i), 1'b0);
    cyc(1'b1, 1'b1, 8'h55, 1'b0);
    check("both_full_dout", data_out, 8'h01);
    check("both_full_count", count, 8);
    check("both_full_ovf", overflow, 0);
    for (int i = 2; i <= 9; i++) begin
      cyc(1'b0, 1'b1, 8'h00, 1'b0);
      check("both_drain", data_out, (i == 9) ? 8'h55 : 8'(i));
    end
    check("both_drain_empty", empty, 1);

    // Simultaneous at empty: write only.
    cyc(1'b1, 1'b1, 8'h33, 1'b0);
    check("both_empty_count", count, 1);
    check("both_empty_unf", underflow, 1);
    check("both_empty_dout", data_out, 8'h55);
    cyc(1'b0, 1'b1, 8'h00, 1'b1);
    check("both_empty_read", data_out, 8'h33);
    check("both_empty_cnt0", count, 0);
    check("both_empty_unfclr", underflow, 0);

    // Wrap-around: mixed write / read / both cycles against a queue model.
    q.delete();
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, 8'(8'h40 + i), 1'b0);
      q.push_back(8'(8'h40 + i));
    end
    for (int i = 0; i < 20; i++) begin
      case (i % 3)
        0: begin
          cyc(1'b1, 1'b0, 8'(8'h80 + i), 1'b0);
          q.push_back(8'(8'h80 + i));
        end
        1: begin
          exp_d = q.pop_front();
          cyc(1'b0, 1'b1, 8'h00, 1'b0);
          check("wrap_rd", data_out, exp_d);
        end
        default: begin
          exp_d = q.pop_front();
          q.push_back(8'(8'h80 + i));
          cyc(1'b1, 1'b1, 8'(8'h80 + i), 1'b0);
          check("wrap_both", data_out, exp_d);
        end
      endcase
      check("wrap_count", count, q.size());
    end
    while (q.size() > 0) begin
      exp_d = q.pop_front();
      cyc(1'b0, 1'b1, 8'h00, 1'b0);
      check("wrap_drain", data_out, exp_d);
    end
    check("wrap_empty", empty, 1);

    // Reset mid-operation at count 5 with overflow set.
    for (int i = 1; i <= 9; i++) cyc(1'b1, 1'b0, 8'(8'h10 + i), 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 8'h00, 1'b0);
    check("pre_rst_count", count, 5);
    check("pre_rst_ovf", overflow, 1);
    reset = 1'b1;
    cyc(1'b1, 1'b0, 8'hEE, 1'b0);
    reset = 1'b0;
    check("mid_rst_count", count, 0);
    check("mid_rst_empty", empty, 1);
    check("mid_rst_ovf", overflow, 0);
    check("mid_rst_dout", data_out, 0);
    check("mid_rst_full", full, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fifo_param.md
FIFO_PARAM -- requirements
Module: fifo_param

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 8, number of storage words (power of 2, >=2).
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-2, occupancy at or above which almost_full asserts.
REQ-004 SHALL have parameter AE_LEVEL, default 2, occupancy at or below which almost_empty asserts.
REQ-005 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port write  input  1  write request.
REQ-008 SHALL have port read  input  1  read request.
REQ-009 SHALL have port data_in  input  WIDTH  write data.
REQ-010 SHALL have port clr_err  input  1  clears sticky error flags.
REQ-011 SHALL have port data_out  output  WIDTH  registered read data.
REQ-012 SHALL have port count  output  log2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-013 SHALL have ports full, empty, almost_full, almost_empty  output  1 each  status flags.
REQ-014 SHALL have ports overflow, underflow  output  1 each  sticky error flags.

Function
REQ-015 SHALL implement storage as DEPTH x WIDTH array with separate write and read pointers of log2(DEPTH) bits, each wrapping DEPTH-1 -> 0.
REQ-016 SHALL accept a write when write=1 and (full=0 or read accepted same cycle): mem[wr_ptr] <= data_in, wr_ptr increments.
REQ-017 SHALL accept a read when read=1 and empty=0: data_out <= mem[rd_ptr] on that edge, rd_ptr increments; read latency exactly 1 cycle.
REQ-018 SHALL hold data_out unchanged on any cycle with no accepted read.
REQ-019 SHALL update count: +1 write-only, -1 read-only, unchanged for both or neither.
REQ-020 SHALL, with both requests while empty, accept write only; reject read; set underflow; count becomes 1.
REQ-021 SHALL, with both requests while full, accept both; count stays DEPTH; read returns oldest word.
REQ-022 SHALL ignore write when full and no read; storage and pointers unchanged; overflow set next edge.
REQ-023 SHALL ignore read when empty; data_out and pointers unchanged; underflow set next edge.
REQ-024 SHALL derive flags combinationally from registered count: full=(count==DEPTH), empty=(count==0), almost_full=(count>=AF_LEVEL), almost_empty=(count<=AE_LEVEL).
REQ-025 SHALL keep overflow/underflow set until clr_err=1 or reset; clr_err and a new error in the same cycle leave the flag set.
REQ-026 SHALL preserve FIFO order across pointer wrap-around for any number of cycles.

Reset
REQ-027 SHALL, on reset=1 at a rising edge, set wr_ptr=0, rd_ptr=0, count=0, data_out=0, overflow=0, underflow=0; empty=1, full=0, almost_empty=1, almost_full=0.
REQ-028 SHALL give reset priority over write, read and clr_err in the same cycle; in-flight operations discarded.
REQ-029 SHALL NOT require storage array contents to be reset.

Verification (WIDTH=8, DEPTH=8, defaults)
REQ-030 SHALL verify fill/drain: write 0x01..0x08 -> full=1, count=8; read 8 times -> data_out 0x01..0x08, each one cycle after read, then empty=1.
REQ-031 SHALL verify overflow: at full, write 0xAA with read=0 -> count stays 8, overflow=1; drain returns 0x01..0x08, no 0xAA; clr_err=1 -> overflow=0.
REQ-032 SHALL verify underflow: read when empty after data_out=0x08 -> data_out stays 0x08, underflow=1, count=0.
REQ-033 SHALL verify simultaneous: at count=8 write 0x55 + read -> data_out=0x01, count=8; at count=0 write 0x33 + read -> count=1, underflow=1, next read returns 0x33.
REQ-034 SHALL verify wrap and thresholds: 20 interleaved write/read cycles -> output order equals input order; almost_full=1 at count 6, almost_empty=1 at count 2.
REQ-035 SHALL verify reset mid-operation: at count=5 with overflow=1, assert reset with write=1 -> count=0, empty=1, overflow=0, data_out=0.
